instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WID, default 64, width of valC and of all PCs.
REQ-002 SHALL have parameter FETCH_BYTES, default 4, bytes returned per memory read (power of 2, 2..16).
REQ-003 SHALL have parameter BUF_BYTES, default 32, byte-buffer depth (power of 2, >= 2*FETCH_BYTES and >= 10).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port redirect_valid  in  1  load new PC and flush.
REQ-007 SHALL have port redirect_pc  in  DATA_WID  new fetch PC.
REQ-008 SHALL have port mem_rd  out  1  memory read request.
REQ-009 SHALL have port mem_addr  out  DATA_WID  byte address of the read.
REQ-010 SHALL have port mem_rdata  in  8*FETCH_BYTES  read data; byte at mem_addr+i on bits [8i+7:8i].
REQ-011 SHALL have port out_valid  out  1  complete instruction at buffer head.
REQ-012 SHALL have port out_ready  in  1  consumer accepts the instruction.
REQ-013 SHALL have ports icode, ifun, rA, rB  out  4 each  decoded fields.
REQ-014 SHALL have port valC  out  DATA_WID  little-endian constant.
REQ-015 SHALL have port valP  out  DATA_WID  head PC plus instruction length.
REQ-016 SHALL have port instr_err  out  1  invalid icode at head.

Function
REQ-017 Memory: mem_rdata SHALL be valid exactly one cycle after mem_rd; memory never stalls; at most one read in flight.
REQ-018 Issue: mem_rd=1 in FILL only when occupancy + FETCH_BYTES*(1 + in-flight) <= BUF_BYTES; mem_addr then advances by FETCH_BYTES; unaligned addresses allowed.
REQ-019 Buffer: circular, byte-granular; same-cycle fill and consume SHALL both apply; pointers wrap modulo BUF_BYTES.
REQ-020 Length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
REQ-021 out_valid SHALL be 1 iff occupancy >= length of head byte, state FILL, and no redirect this cycle.
REQ-022 Fields: icode/ifun from head byte [7:4]/[3:0]; rA/rB from byte 1 [7:4]/[3:0], 0 when length 1; valC from bytes 1..8 for icode 7/8, bytes 2..9 for icode 3/4/5, else 0.
REQ-023 Outputs SHALL stay stable while out_valid=1 and out_ready=0; handshake completes when both are 1, removing length bytes and setting head PC to valP.
REQ-024 FSM states IDLE, FILL, HALTED: IDLE->FILL on the first cycle after reset; FILL->HALTED on consuming icode 0; HALTED->FILL only on redirect.
REQ-025 HALTED: mem_rd=0, buffer empty, out_valid=0.
REQ-026 Redirect (any state) SHALL take priority over consume and fill: buffer cleared, any in-flight response dropped, head PC and mem_addr set to redirect_pc, state FILL; first new read the following cycle.

Reset
REQ-027 Reset SHALL force: state IDLE, head PC 0, fetch PC 0, occupancy 0, in-flight 0, mem_rd 0, mem_addr 0, out_valid 0, instr_err 0.
REQ-028 Reset asserted mid-read SHALL discard the pending response.

Configuration
REQ-029 With INSTR_ERR_EN defined: icode > B gives length 1 and instr_err=1 with out_valid; consuming it enters HALTED.
REQ-030 Without INSTR_ERR_EN: instr_err tied 0; icode > B decodes as length 1 with no halt.

Structure
REQ-031 Shared package y86_pkg SHALL hold the icode constants (I_HALT..I_POPQ) and the FSM state enum.
REQ-032 The icode-to-length decode SHALL be sub-module instr_len_decode (combinational), instantiated once.

Verification
REQ-033 Memory 30 F2 0A 00 00 00 00 00 00 00 at 0 -> icode 3, ifun 0, rA F, rB 2, valC 0xA, valP 0xA.
REQ-034 Bytes 70 00 01 00 00 00 00 00 00 at 0 -> icode 7, valC 0x100, valP 9; then redirect_pc 0x100 -> next instruction fetched from 0x100.
REQ-035 out_ready=0 for 5 cycles with 10 nop bytes (0x10) -> fields held; buffer stops at BUF_BYTES; no data loss after release.
REQ-036 Redirect to 0x40 in the cycle a response returns -> response dropped; first out_valid has PC 0x40.
REQ-037 Bytes 10 00 10 -> nop, then halt consumed, then mem_rd=0 and out_valid=0 until redirect.
REQ-038 With INSTR_ERR_EN, byte C0 at 0 -> instr_err=1 and out_valid=1; after consume, HALTED.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: icode constants and fetch FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HALTED
    } state_t;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational icode -> instruction byte length.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len
);

    always_comb begin
        len = 4'd1;
        case (icode)
            I_HALT, I_NOP, I_RET:              len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  len = 4'd2;
            I_JXX, I_CALL:                     len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      len = 4'd10;
            default:                           len = 4'd1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Y86 fetch: byte ring buffer fed by fixed-width reads, decodes head instruction.
// Define INSTR_ERR_EN to flag and halt on icodes above POPQ.
module instr_fetch_unit
    import y86_pkg::*;
#(
    parameter int DATA_WID    = 64,
    parameter int FETCH_BYTES = 4,
    parameter int BUF_BYTES   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [DATA_WID-1:0]      redirect_pc,
    output logic                     mem_rd,
    output logic [DATA_WID-1:0]      mem_addr,
    input  logic [8*FETCH_BYTES-1:0] mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               icode,
    output logic [3:0]               ifun,
    output logic [3:0]               rA,
    output logic [3:0]               rB,
    output logic [DATA_WID-1:0]      valC,
    output logic [DATA_WID-1:0]      valP,
    output logic                     instr_err
);

    localparam int PW = $clog2(BUF_BYTES);
    localparam int OW = PW + 1;
    localparam int NW = OW + 1;

    state_t              state, state_d;
    logic [7:0]          buf_q [BUF_BYTES];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [OW-1:0]       occ;
    logic                inflight;
    logic [DATA_WID-1:0] head_pc, fetch_pc;

    logic [7:0]          hb [10];
    logic [3:0]          len;
    logic [63:0]         c64;
    logic [NW-1:0]       need;
    logic                fill, fire, halt_now;

    always_comb begin
        for (int i = 0; i < 10; i++)
            hb[i] = buf_q[rd_ptr + PW'(i)];
    end

    instr_len_decode u_len (
        .icode (hb[0][7:4]),
        .len   (len)
    );

    assign icode = hb[0][7:4];
    assign ifun  = hb[0][3:0];
    assign rA    = (len == 4'd1) ? 4'h0 : hb[1][7:4];
    assign rB    = (len == 4'd1) ? 4'h0 : hb[1][3:0];
    assign valP  = head_pc + DATA_WID'(len);

    always_comb begin
        c64 = '0;
        unique case (1'b1)
            (icode == I_JXX || icode == I_CALL):
                c64 = {hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2], hb[1]};
            (icode == I_IRMOVQ || icode == I_RMMOVQ || icode == I_MRMOVQ):
                c64 = {hb[9], hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2]};
            default:
                c64 = '0;
        endcase
    end

    assign valC = DATA_WID'(c64);

    // Room must exist for the in-flight response as well as the new one.
    assign need = NW'(occ) + (inflight ? NW'(2 * FETCH_BYTES) : NW'(FETCH_BYTES));

    assign mem_rd    = (state == FILL) && !redirect_valid && (need <= NW'(BUF_BYTES));
    assign mem_addr  = fetch_pc;
    assign out_valid = (state == FILL) && !redirect_valid && (occ >= OW'(len));
    assign fill      = inflight && (state == FILL) && !redirect_valid;
    assign fire      = out_valid && out_ready;

`ifdef INSTR_ERR_EN
    logic bad;
    assign bad       = icode > I_POPQ;
    assign instr_err = out_valid & bad;
    assign halt_now  = fire & ((icode == I_HALT) | bad);
`else
    assign instr_err = 1'b0;
    assign halt_now  = fire & (icode == I_HALT);
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = FILL;
            FILL:    if (halt_now) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (redirect_valid)
            state_d = FILL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_pc  <= '0;
            fetch_pc <= '0;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            head_pc  <= redirect_pc;
            fetch_pc <= redirect_pc;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else if (halt_now) begin
            head_pc  <= valP;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_rd;
            if (mem_rd)
                fetch_pc <= fetch_pc + DATA_WID'(FETCH_BYTES);
            if (fill)
                wr_ptr <= wr_ptr + PW'(FETCH_BYTES);
            if (fire) begin
                rd_ptr  <= rd_ptr + PW'(len);
                head_pc <= valP;
            end
            occ <= occ + (fill ? OW'(FETCH_BYTES) : '0) - (fire ? OW'(len) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (fill)
            for (int i = 0; i < FETCH_BYTES; i++)
                buf_q[wr_ptr + PW'(i)] <= mem_rdata[8*i +: 8];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, instruction-stream reference, directed vectors.
module tb_instr_fetch_unit;

    localparam int DW    = 64;
    localparam int FB    = 4;
    localparam int BB    = 32;
    localparam int MEMSZ = 4096;
`ifdef INSTR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [DW-1:0] redirect_pc = '0;
    logic          mem_rd;
    logic [DW-1:0] mem_addr;
    logic [8*FB-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    icode, ifun, rA, rB;
    logic [DW-1:0] valC, valP;
    logic          instr_err;

    logic [7:0]    mem [MEMSZ];
    int            vectors = 0;
    int            miscompares = 0;

    logic [DW-1:0] mpc;
    bit            m_halted;
    int            nfired;
    int            nreads;
    logic [7:0]    b0, b1;
    logic [3:0]    e_ic;
    int            e_len;
    logic [63:0]   e_c;

    instr_fetch_unit #(
        .DATA_WID    (DW),
        .FETCH_BYTES (FB),
        .BUF_BYTES   (BB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .icode          (icode),
        .ifun           (ifun),
        .rA             (rA),
        .rB             (rB),
        .valC           (valC),
        .valP           (valP),
        .instr_err      (instr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd)
            for (int i = 0; i < FB; i++)
                mem_rdata[8*i +: 8] <= mem[(int'(mem_addr[11:0]) + i) % MEMSZ];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [7:0] mb(input logic [DW-1:0] a);
        return mem[a[11:0]];
    endfunction

    function automatic logic [63:0] le8(input logic [DW-1:0] a);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r = r | (64'(mb(a + DW'(i))) << (8 * i));
        return r;
    endfunction

    // Reference: the instruction at mpc in memory is what the head must show.
    always @(negedge clk) begin
        if (rst) begin
            mpc      = '0;
            m_halted = 1'b0;
        end else begin
            if (redirect_valid)
                check("ov_on_redirect", 64'(out_valid), 64'd0);
            b0    = mb(mpc);
            b1    = mb(mpc + 1);
            e_ic  = b0[7:4];
            e_len = ref_len(e_ic);
            if (e_ic == 4'h7 || e_ic == 4'h8)
                e_c = le8(mpc + 1);
            else if (e_ic == 4'h3 || e_ic == 4'h4 || e_ic == 4'h5)
                e_c = le8(mpc + 2);
            else
                e_c = '0;
            if (m_halted) begin
                check("halted_mem_rd", 64'(mem_rd), 64'd0);
                check("halted_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                check("icode", 64'(icode), 64'(e_ic));
                check("ifun", 64'(ifun), 64'(b0[3:0]));
                check("rA", 64'(rA), (e_len == 1) ? 64'd0 : 64'(b1[7:4]));
                check("rB", 64'(rB), (e_len == 1) ? 64'd0 : 64'(b1[3:0]));
                check("valC", valC, e_c);
                check("valP", valP, mpc + DW'(e_len));
                check("instr_err", 64'(instr_err), 64'(ERR_EN && e_ic > 4'hB));
            end
            if (mem_rd)
                nreads++;
            if (redirect_valid) begin
                mpc      = redirect_pc;
                m_halted = 1'b0;
            end else if (out_valid && out_ready && !m_halted) begin
                nfired++;
                mpc = mpc + DW'(e_len);
                if (e_ic == 4'h0 || (ERR_EN && e_ic > 4'hB))
                    m_halted = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        cyc(2);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_instr_err", 64'(instr_err), 64'd0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(mem_rd), 64'd1);
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(m_halted), 64'd1);
    endtask

    task automatic accept_one();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic redirect(input logic [DW-1:0] pc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        nreads = 0;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic put(input int a, input logic [7:0] b);
        mem[a] = b;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < MEMSZ; i++)
            mem[i] = 8'h00;
        nfired = 0;
        nreads = 0;

        // irmovq $0xA, %rdx then halt
        put(0, 8'h30); put(1, 8'hF2); put(2, 8'h0A);
        do_reset();
        wait_valid("t1_valid");
        check("t1_icode", 64'(icode), 64'h3);
        check("t1_ifun", 64'(ifun), 64'h0);
        check("t1_rA", 64'(rA), 64'hF);
        check("t1_rB", 64'(rB), 64'h2);
        check("t1_valC", valC, 64'hA);
        check("t1_valP", valP, 64'hA);
        accept_one();
        wait_valid("t1_halt_valid");
        check("t1_halt_icode", 64'(icode), 64'h0);
        check("t1_halt_valP", valP, 64'hB);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_halt("t1_halted");
        cyc(5);
        out_ready = 1'b0;

        // jmp 0x100; reset lands while a read is outstanding
        for (int i = 0; i < 10; i++)
            put(i, 8'h00);
        put(0, 8'h70); put(2, 8'h01);
        put(12'h100, 8'h60); put(12'h101, 8'h12); put(12'h102, 8'h00);
        do_reset();
        wait_rd("t2_rd_seen");
        do_reset();
        wait_valid("t2_valid");
        check("t2_icode", 64'(icode), 64'h7);
        check("t2_valC", valC, 64'h100);
        check("t2_valP", valP, 64'h9);
        accept_one();
        redirect(64'h100);
        wait_valid("t2_tgt_valid");
        check("t2_tgt_icode", 64'(icode), 64'h6);
        check("t2_tgt_rA", 64'(rA), 64'h1);
        check("t2_tgt_rB", 64'(rB), 64'h2);
        check("t2_tgt_valP", valP, 64'h102);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_halt("t2_halted");
        out_ready = 1'b0;

        // 10 nops under backpressure
        for (int i = 0; i < 10; i++)
            put(12'h200 + i, 8'h10);
        redirect(64'h200);
        cyc(25);
        check("t3_reads_fill_buf", 64'(nreads), 64'(BB / FB));
        check("t3_held_icode", 64'(icode), 64'h1);
        check("t3_held_valP", valP, 64'h201);
        check("t3_held_valid", 64'(out_valid), 64'd1);
        n0 = nfired;
        out_ready = 1'b1;
        wait_halt("t3_halted");
        check("t3_fired", 64'(nfired - n0), 64'd11);
        out_ready = 1'b0;

        // redirect to 0x40 exactly when a response returns
        for (int i = 0; i < 64; i++)
            put(12'h300 + i, 8'h10);
        put(12'h40, 8'h20); put(12'h41, 8'h34); put(12'h42, 8'h00);
        redirect(64'h300);
        wait_rd("t4_rd_seen");
        redirect(64'h40);
        wait_valid("t4_valid");
        check("t4_icode", 64'(icode), 64'h2);
        check("t4_rA", 64'(rA), 64'h3);
        check("t4_rB", 64'(rB), 64'h4);
        check("t4_valP", valP, 64'h42);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_halt("t4_halted");
        out_ready = 1'b0;

        // nop, halt, then quiet until redirect
        put(12'h80, 8'h10); put(12'h81, 8'h00); put(12'h82, 8'h10);
        n0 = nfired;
        redirect(64'h80);
        out_ready = 1'b1;
        wait_halt("t5_halted");
        check("t5_fired", 64'(nfired - n0), 64'd2);
        cyc(5);
        check("t5_mem_rd", 64'(mem_rd), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // icode C at 0
        for (int i = 0; i < 10; i++)
            put(i, 8'h00);
        put(0, 8'hC0); put(1, 8'h10);
        do_reset();
        wait_valid("t6_valid");
        check("t6_icode", 64'(icode), 64'hC);
        check("t6_valP", valP, 64'h1);
        check("t6_instr_err", 64'(instr_err), 64'(ERR_EN));
        accept_one();
        cyc(3);
        check("t6_after_valid", 64'(out_valid), ERR_EN ? 64'd0 : 64'd1);
        if (!ERR_EN) begin
            check("t6_after_icode", 64'(icode), 64'h1);
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        wait_halt("t6_halted");
        out_ready = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
